md_arbiter: RTL and testbench

- Sequences and shares the single HI/LO multiply/divide unit between two requesters: requester 0 is the pipeline E stage, requester 1 is the debug/coprocessor port.
- Arbitrates round-robin and issues exactly one op per transaction to the unit as a one-cycle aluop pulse with operands.
- Counts the unit's fixed latency and returns the HI/LO result to the owning requester with a one-cycle response strobe.
- Sits between the requesters and the unit; it does not compute anything itself.

---
 rtl/md_arbiter.sv | 159 +++++++++++++++
 tb/tb_md_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_arbiter.sv
// Round-robin arbiter that shares one HI/LO multiply/divide unit between two requesters.
// Issues a one-cycle aluop pulse, counts the unit latency and returns HI/LO to the owner.
module md_arbiter #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [2:0]  op0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        req1,
  input  logic [2:0]  op1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [2:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        busy,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_e            state_q;
  logic              ptr_q;
  logic              id_q;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        md_op_q;
  logic [31:0]       md_a_q;
  logic [31:0]       md_b_q;

  logic              valid0_s;
  logic              valid1_s;
  logic              open_s;
  logic              take_s;
  logic              win_s;
  logic [2:0]        sel_op_s;
  logic [31:0]       sel_a_s;
  logic [31:0]       sel_b_s;

  function automatic logic op_ok(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd6);
  endfunction

  // Winner selection; grants are gated by reset so nothing is offered while it is held
  always_comb begin
    valid0_s = req0 && op_ok(op0);
    valid1_s = req1 && op_ok(op1);
    open_s   = ((state_q == IDLE) || (state_q == DONE)) && !reset;
    take_s   = 1'b0;
    win_s    = 1'b0;
    if (open_s && valid0_s && valid1_s) begin
      take_s = 1'b1;
      win_s  = ptr_q;
    end else if (open_s && valid0_s) begin
      take_s = 1'b1;
      win_s  = 1'b0;
    end else if (open_s && valid1_s) begin
      take_s = 1'b1;
      win_s  = 1'b1;
    end else begin
      take_s = 1'b0;
      win_s  = 1'b0;
    end
    sel_op_s = win_s ? op1 : op0;
    sel_a_s  = win_s ? a1  : a0;
    sel_b_s  = win_s ? b1  : b0;
  end

  // Transaction sequencer: grant, one-cycle issue, latency countdown, response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= 3'd0;
      cnt_q   <= '0;
      md_op_q <= 3'd0;
      md_a_q  <= 32'd0;
      md_b_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (take_s) begin
            id_q    <= win_s;
            op_q    <= sel_op_s;
            md_op_q <= sel_op_s;
            md_a_q  <= sel_a_s;
            md_b_q  <= sel_b_s;
            ptr_q   <= ~win_s;
            state_q <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          md_op_q <= 3'd0;
          case (op_q)
            3'd1, 3'd2: begin
              if (MUL_LAT == 1) begin
                state_q <= DONE;
              end else begin
                cnt_q   <= MUL_CNT;
                state_q <= WAIT;
              end
            end
            3'd3, 3'd4: begin
              if (DIV_LAT == 1) begin
                state_q <= DONE;
              end else begin
                cnt_q   <= DIV_CNT;
                state_q <= WAIT;
              end
            end
            default: state_q <= DONE;
          endcase
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // HI/LO pass-through is zeroed outside the DONE strobe
  always_comb begin
    gnt0      = take_s && !win_s;
    gnt1      = take_s && win_s;
    md_op     = md_op_q;
    md_a      = md_a_q;
    md_b      = md_b_q;
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == DONE) && !reset;
    rsp_id    = rsp_valid && id_q;
    rsp_hi    = rsp_valid ? md_hi : 32'd0;
    rsp_lo    = rsp_valid ? md_lo : 32'd0;
  end

endmodule

// File: tb/tb_md_arbiter.sv
// Scoreboard bench for md_arbiter: a transaction-level model predicts grants, issues and responses;
// a monitor compares every issue pulse and response strobe against the queued expectations.
module tb_md_arbiter;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b, md_hi, md_lo;
  logic        busy, rsp_valid, rsp_id;
  logic [31:0] rsp_hi, rsp_lo;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {int due; logic id; logic [31:0] hi; logic [31:0] lo;} rsp_t;
  typedef struct {int due; logic [2:0] op; logic [31:0] a; logic [31:0] b;} iss_t;
  rsp_t rsp_q[$];
  iss_t iss_q[$];
  rsp_t mon_r;
  iss_t mon_i;

  logic        m_ptr;
  int          m_free;
  int          m_busy_from;
  logic [63:0] m_hilo;
  logic        g0_m, g1_m;
  logic [63:0] unit_hilo;

  always #5 clk = ~clk;

  md_arbiter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .md_hi(md_hi), .md_lo(md_lo),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo)
  );

  // MIPS HI/LO semantics: mult -> {hi,lo}=product; div -> lo=quotient, hi=remainder
  function automatic logic [63:0] unit_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] old);
    longint sa, sb;
    logic [63:0] r;
    r  = old;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: r = 64'(sa * sb);
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3: if (b != 32'd0) r = {32'(sa % sb), 32'(sa / sb)};
      3'd4: if (b != 32'd0) r = {a % b, a / b};
      3'd5: r[63:32] = a;
      3'd6: r[31:0] = a;
      default: r = old;
    endcase
    return r;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural HI/LO unit: samples the aluop pulse at the edge
  always @(posedge clk or posedge reset) begin
    if (reset) unit_hilo <= 64'd0;
    else if (md_op != 3'd0) unit_hilo <= unit_calc(md_op, md_a, md_b, unit_hilo);
  end
  assign md_hi = unit_hilo[63:32];
  assign md_lo = unit_hilo[31:0];

  // Monitor: pops expectations whenever the DUT presents an issue pulse or response
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_valid_unexpected", rsp_valid, 64'd0);
        end else begin
          mon_r = rsp_q.pop_front();
          check("rsp_cycle", cyc, mon_r.due);
          check("rsp_id", rsp_id, mon_r.id);
          check("rsp_hi", rsp_hi, mon_r.hi);
          check("rsp_lo", rsp_lo, mon_r.lo);
        end
      end else begin
        check("rsp_hilo_idle", {rsp_hi, rsp_lo}, 64'd0);
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          check("rsp_valid_missing", rsp_valid, 64'd1);
          void'(rsp_q.pop_front());
        end
      end
      if (md_op != 3'd0) begin
        if (iss_q.size() == 0) begin
          check("md_op_unexpected", md_op, 64'd0);
        end else begin
          mon_i = iss_q.pop_front();
          check("md_op_cycle", cyc, mon_i.due);
          check("md_op", md_op, mon_i.op);
          check("md_a", md_a, mon_i.a);
          check("md_b", md_b, mon_i.b);
        end
      end else if (iss_q.size() > 0 && iss_q[0].due <= cyc) begin
        check("md_op_missing", md_op, iss_q[0].op);
        void'(iss_q.pop_front());
      end
    end
  end

  // One clock of stimulus: predict grant from the rules, compare, queue expectations
  task automatic step();
    logic v0, v1, win;
    logic [2:0] op;
    logic [31:0] a, b;
    int lat;
    @(negedge clk);
    v0 = req0 && (op0 inside {[3'd1:3'd6]});
    v1 = req1 && (op1 inside {[3'd1:3'd6]});
    check("busy", busy, (cyc >= m_busy_from) && (cyc <= m_free));
    g0_m = 1'b0;
    g1_m = 1'b0;
    if (cyc >= m_free && (v0 || v1)) begin
      win = (v0 && v1) ? m_ptr : v1;
      op  = win ? op1 : op0;
      a   = win ? a1 : a0;
      b   = win ? b1 : b0;
      lat = (op >= 3'd5) ? 1 : ((op <= 3'd2) ? MUL_LAT : DIV_LAT);
      m_hilo = unit_calc(op, a, b, m_hilo);
      rsp_q.push_back('{cyc + lat + 1, win, m_hilo[63:32], m_hilo[31:0]});
      iss_q.push_back('{cyc + 1, op, a, b});
      m_ptr       = !win;
      m_busy_from = cyc + 1;
      m_free      = cyc + lat + 1;
      g0_m        = !win;
      g1_m        = win;
    end
    check("gnt0", gnt0, g0_m);
    check("gnt1", gnt1, g1_m);
    @(posedge clk);
    #1;
  endtask

  // Steps until both pending requests have been granted (bounded)
  task automatic serve();
    int k;
    k = 0;
    while ((req0 || req1) && k < 80) begin
      step();
      if (g0_m) req0 = 1'b0;
      if (g1_m) req1 = 1'b0;
      k++;
    end
    if (k >= 80) check("grant_timeout", {req0, req1}, 64'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_gnt", {gnt0, gnt1}, 64'd0);
    check("rst_md", {md_op, md_a, md_b}, 64'd0);
    check("rst_rsp", {rsp_valid, rsp_id, busy}, 64'd0);
    check("rst_rsp_data", {rsp_hi, rsp_lo}, 64'd0);
    rsp_q.delete();
    iss_q.delete();
    m_ptr = 1'b0;
    m_free = -1;
    m_busy_from = 0;
    m_hilo = 64'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic load0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req0 = 1'b1; op0 = op; a0 = a; b0 = b;
  endtask

  task automatic load1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req1 = 1'b1; op1 = op; a1 = a; b1 = b;
  endtask

  initial begin
    reset = 1'b0;
    req0 = 1'b0; op0 = 3'd0; a0 = 32'd0; b0 = 32'd0;
    req1 = 1'b0; op1 = 3'd0; a1 = 32'd0; b1 = 32'd0;
    m_ptr = 1'b0; m_free = -1; m_busy_from = 0; m_hilo = 64'd0;
    g0_m = 1'b0; g1_m = 1'b0;
    @(posedge clk);
    #1;
    load0(3'd1, 32'd3, 32'hFFFF_FFFE);
    do_reset();

    // mult 3 * -2 from requester 0
    serve();
    repeat (MUL_LAT + 2) step();

    // simultaneous div / divu from a fresh pointer
    do_reset();
    load0(3'd3, 32'd7, 32'd2);
    load1(3'd4, 32'd9, 32'd4);
    serve();
    repeat (DIV_LAT + 2) step();

    // continuous requesting from both sides
    load0(3'd5, $urandom, 32'd0);
    load1(3'd6, $urandom, 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (g0_m) load0(3'($urandom_range(1, 6)), $urandom, $urandom_range(1, 100));
      if (g1_m) load1(3'($urandom_range(5, 6)), $urandom, $urandom);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (DIV_LAT + 2) step();

    // mthi then mtlo from requester 1
    load1(3'd5, 32'h1234, 32'd0);
    serve();
    load1(3'd6, 32'h5678, 32'd0);
    serve();
    repeat (3) step();

    // invalid ops are never granted
    load0(3'd0, 32'hAAAA, 32'h5555);
    repeat (4) step();
    load0(3'd7, 32'hAAAA, 32'h5555);
    repeat (4) step();
    req0 = 1'b0;

    // reset during WAIT of a divide; request held through reset
    load0(3'd3, 32'd100, 32'd7);
    serve();
    repeat (4) step();
    load0(3'd4, 32'd50, 32'd6);
    do_reset();
    serve();
    repeat (DIV_LAT + 3) step();

    // randomized traffic including invalid ops and divide by zero
    for (int i = 0; i < 600; i++) begin
      if (!req0 && $urandom_range(0, 2) == 0)
        load0(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
      if (!req1 && $urandom_range(0, 2) == 0)
        load1(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1000));
      step();
      if (g0_m) req0 = 1'b0;
      else if (req0 && !(op0 inside {[3'd1:3'd6]}) && $urandom_range(0, 3) == 0) req0 = 1'b0;
      if (g1_m) req1 = 1'b0;
      else if (req1 && !(op1 inside {[3'd1:3'd6]}) && $urandom_range(0, 3) == 0) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (DIV_LAT + 3) step();
    check("rsp_queue_drained", rsp_q.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
